// File: rtl/huff_mcu_sched.sv
// huff_mcu_sched
//   Merges the Y, Cb and Cr Huffman encoder word streams into one output
//   stream in JPEG MCU order: Y_PER_MCU Y blocks, one Cb block, one Cr block,
//   repeated num_mcu times. A single output register isolates the encoders
//   from downstream backpressure while still allowing one word per cycle.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   start, num_mcu           begin an image of num_mcu MCUs (accepted in IDLE only)
//   {y,cb,cr}_valid/ready    per-source handshake; only the granted source sees ready
//   {y,cb,cr}_data/last/bits per-source word, end-of-block flag, final-word bit count
//   out_valid/out_ready      output handshake
//   out_data/last/bits/comp  held word, end-of-block flag, bit count (last only), source id
//   busy, done, mcu_idx      status: not idle, end-of-image pulse, MCU being granted
module huff_mcu_sched #(
  parameter int WORD_W    = 32,
  parameter int CNT_W     = 5,
  parameter int Y_PER_MCU = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_mcu,
  input  logic              y_valid,
  output logic              y_ready,
  input  logic [WORD_W-1:0] y_data,
  input  logic              y_last,
  input  logic [CNT_W-1:0]  y_bits,
  input  logic              cb_valid,
  output logic              cb_ready,
  input  logic [WORD_W-1:0] cb_data,
  input  logic              cb_last,
  input  logic [CNT_W-1:0]  cb_bits,
  input  logic              cr_valid,
  output logic              cr_ready,
  input  logic [WORD_W-1:0] cr_data,
  input  logic              cr_last,
  input  logic [CNT_W-1:0]  cr_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  out_bits,
  output logic [1:0]        out_comp,
  output logic              busy,
  output logic              done,
  output logic [15:0]       mcu_idx
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GNT_Y  = 3'd1,
    ST_GNT_CB = 3'd2,
    ST_GNT_CR = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  // Index of the final Y block inside one MCU.
  localparam logic [1:0] Y_LAST_BLK = 2'(Y_PER_MCU - 1);

  state_t              state_r;
  logic [1:0]          yblk_r;
  logic [15:0]         mcu_idx_r;
  logic [15:0]         num_mcu_r;
  logic                busy_r;
  logic                done_r;

  logic                out_valid_r;
  logic [WORD_W-1:0]   out_data_r;
  logic                out_last_r;
  logic [CNT_W-1:0]    out_bits_r;
  logic [1:0]          out_comp_r;

  logic                room_s;
  logic                consume_s;
  logic                acc_valid_s;
  logic [WORD_W-1:0]   acc_data_s;
  logic                acc_last_s;
  logic [CNT_W-1:0]    acc_bits_s;
  logic [1:0]          acc_comp_s;
  logic                acc_blk_end_s;

  // The output register can take a word when empty or when it drains this cycle.
  assign consume_s = out_valid_r & out_ready;
  assign room_s    = ~out_valid_r | out_ready;

  assign y_ready  = (state_r == ST_GNT_Y)  & room_s;
  assign cb_ready = (state_r == ST_GNT_CB) & room_s;
  assign cr_ready = (state_r == ST_GNT_CR) & room_s;

  // Select the granted source and flag whether its word is accepted this cycle.
  always_comb begin
    acc_valid_s = 1'b0;
    acc_data_s  = {WORD_W{1'b0}};
    acc_last_s  = 1'b0;
    acc_bits_s  = {CNT_W{1'b0}};
    acc_comp_s  = 2'd0;
    case (state_r)
      ST_GNT_Y: begin
        acc_valid_s = y_valid & room_s;
        acc_data_s  = y_data;
        acc_last_s  = y_last;
        acc_bits_s  = y_bits;
        acc_comp_s  = 2'd0;
      end
      ST_GNT_CB: begin
        acc_valid_s = cb_valid & room_s;
        acc_data_s  = cb_data;
        acc_last_s  = cb_last;
        acc_bits_s  = cb_bits;
        acc_comp_s  = 2'd1;
      end
      ST_GNT_CR: begin
        acc_valid_s = cr_valid & room_s;
        acc_data_s  = cr_data;
        acc_last_s  = cr_last;
        acc_bits_s  = cr_bits;
        acc_comp_s  = 2'd2;
      end
      default: begin
        acc_valid_s = 1'b0;
      end
    endcase
  end

  assign acc_blk_end_s = acc_valid_s & acc_last_s;

  // Output register: load on accept (no bubble on simultaneous consume), empty on consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WORD_W{1'b0}};
      out_last_r  <= 1'b0;
      out_bits_r  <= {CNT_W{1'b0}};
      out_comp_r  <= 2'd0;
    end else if (acc_valid_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= acc_data_s;
      out_last_r  <= acc_last_s;
      // Bit count is only meaningful on the final word of a block.
      out_bits_r  <= acc_last_s ? acc_bits_s : {CNT_W{1'b0}};
      out_comp_r  <= acc_comp_s;
    end else if (consume_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Grant sequencer with MCU/block counters and registered busy/done status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      yblk_r    <= 2'd0;
      mcu_idx_r <= 16'd0;
      num_mcu_r <= 16'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            num_mcu_r <= num_mcu;
            mcu_idx_r <= 16'd0;
            yblk_r    <= 2'd0;
            busy_r    <= 1'b1;
            // An empty image still passes through DRAIN so done is reported.
            state_r   <= (num_mcu != 16'd0) ? ST_GNT_Y : ST_DRAIN;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_GNT_Y: begin
          if (acc_blk_end_s) begin
            if (yblk_r == Y_LAST_BLK) begin
              yblk_r  <= 2'd0;
              state_r <= ST_GNT_CB;
            end else begin
              yblk_r <= yblk_r + 2'd1;
            end
          end
        end
        ST_GNT_CB: begin
          if (acc_blk_end_s) begin
            state_r <= ST_GNT_CR;
          end
        end
        ST_GNT_CR: begin
          if (acc_blk_end_s) begin
            if (mcu_idx_r == (num_mcu_r - 16'd1)) begin
              state_r <= ST_DRAIN;
            end else begin
              mcu_idx_r <= mcu_idx_r + 16'd1;
              state_r   <= ST_GNT_Y;
            end
          end
        end
        ST_DRAIN: begin
          // Image ends once the last word has left the output register.
          if (!out_valid_r || consume_s) begin
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            mcu_idx_r <= 16'd0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign out_bits  = out_bits_r;
  assign out_comp  = out_comp_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign mcu_idx   = mcu_idx_r;

endmodule

// huff_mcu_sched_chk
//   Property checker for huff_mcu_sched: at most one source is offered ready.
// Ports
//   clk, rst                 clock and active-low reset of the observed block
//   y_ready/cb_ready/cr_ready ready outputs of the observed block
module huff_mcu_sched_chk (
  input logic clk,
  input logic rst,
  input logic y_ready,
  input logic cb_ready,
  input logic cr_ready
);

  a_one_ready: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({y_ready, cb_ready, cr_ready}));

endmodule

// File: tb/tb_huff_mcu_sched.sv
module tb_huff_mcu_sched;
  localparam int W = 32;
  localparam int C = 5;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [C-1:0] bits;
    logic [15:0]  mcu;
  } src_t;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [C-1:0] bits;
    logic [1:0]   comp;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, sel, out_ready;
  logic [15:0] num_mcu;
  logic y_valid, cb_valid, cr_valid;
  logic [W-1:0] y_data, cb_data, cr_data;
  logic y_last, cb_last, cr_last;
  logic [C-1:0] y_bits, cb_bits, cr_bits;

  // per-instance outputs (1: Y_PER_MCU=1, 4: Y_PER_MCU=4)
  logic y_ready_1, cb_ready_1, cr_ready_1, out_valid_1, out_last_1, busy_1, done_1;
  logic y_ready_4, cb_ready_4, cr_ready_4, out_valid_4, out_last_4, busy_4, done_4;
  logic [W-1:0] out_data_1, out_data_4;
  logic [C-1:0] out_bits_1, out_bits_4;
  logic [1:0]   out_comp_1, out_comp_4;
  logic [15:0]  mcu_idx_1, mcu_idx_4;

  // selected instance view
  logic y_ready, cb_ready, cr_ready, out_valid, out_last, busy, done;
  logic [W-1:0] out_data;
  logic [C-1:0] out_bits;
  logic [1:0]   out_comp;
  logic [15:0]  mcu_idx;

  always #5 clk = ~clk;

  huff_mcu_sched #(.WORD_W(W), .CNT_W(C), .Y_PER_MCU(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start & ~sel), .num_mcu(num_mcu),
    .y_valid(y_valid & ~sel), .y_ready(y_ready_1), .y_data(y_data), .y_last(y_last), .y_bits(y_bits),
    .cb_valid(cb_valid & ~sel), .cb_ready(cb_ready_1), .cb_data(cb_data), .cb_last(cb_last), .cb_bits(cb_bits),
    .cr_valid(cr_valid & ~sel), .cr_ready(cr_ready_1), .cr_data(cr_data), .cr_last(cr_last), .cr_bits(cr_bits),
    .out_valid(out_valid_1), .out_ready(out_ready), .out_data(out_data_1), .out_last(out_last_1),
    .out_bits(out_bits_1), .out_comp(out_comp_1), .busy(busy_1), .done(done_1), .mcu_idx(mcu_idx_1));

  huff_mcu_sched #(.WORD_W(W), .CNT_W(C), .Y_PER_MCU(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start & sel), .num_mcu(num_mcu),
    .y_valid(y_valid & sel), .y_ready(y_ready_4), .y_data(y_data), .y_last(y_last), .y_bits(y_bits),
    .cb_valid(cb_valid & sel), .cb_ready(cb_ready_4), .cb_data(cb_data), .cb_last(cb_last), .cb_bits(cb_bits),
    .cr_valid(cr_valid & sel), .cr_ready(cr_ready_4), .cr_data(cr_data), .cr_last(cr_last), .cr_bits(cr_bits),
    .out_valid(out_valid_4), .out_ready(out_ready), .out_data(out_data_4), .out_last(out_last_4),
    .out_bits(out_bits_4), .out_comp(out_comp_4), .busy(busy_4), .done(done_4), .mcu_idx(mcu_idx_4));

  huff_mcu_sched_chk u_chk1 (.clk(clk), .rst(rst), .y_ready(y_ready_1), .cb_ready(cb_ready_1), .cr_ready(cr_ready_1));
  huff_mcu_sched_chk u_chk4 (.clk(clk), .rst(rst), .y_ready(y_ready_4), .cb_ready(cb_ready_4), .cr_ready(cr_ready_4));

  assign y_ready   = sel ? y_ready_4   : y_ready_1;
  assign cb_ready  = sel ? cb_ready_4  : cb_ready_1;
  assign cr_ready  = sel ? cr_ready_4  : cr_ready_1;
  assign out_valid = sel ? out_valid_4 : out_valid_1;
  assign out_data  = sel ? out_data_4  : out_data_1;
  assign out_last  = sel ? out_last_4  : out_last_1;
  assign out_bits  = sel ? out_bits_4  : out_bits_1;
  assign out_comp  = sel ? out_comp_4  : out_comp_1;
  assign busy      = sel ? busy_4      : busy_1;
  assign done      = sel ? done_4      : done_1;
  assign mcu_idx   = sel ? mcu_idx_4   : mcu_idx_1;

  src_t yq[$], cbq[$], crq[$];
  exp_t sbq[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int rmode = 0, stall_lo = 0;
  int out_seen = 0, first_out_cyc = 0, last_out_cyc = 0, done_seen = 0;
  bit drv_en = 1'b0, mon_en = 1'b0;
  bit done_exp = 1'b0, hold_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;
  logic [C-1:0] prev_bits;
  logic [1:0]   prev_comp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a block is a list of words; the merged stream is simply the
  // concatenation of blocks in MCU order, so expectations are queued here.
  task automatic push_block(input int comp, input int mcu, input int nw, input int lastbits);
    src_t s;
    exp_t e;
    for (int w = 0; w < nw; w++) begin
      s.data = $urandom;
      s.last = (w == nw - 1);
      s.bits = 5'($urandom);
      if (s.last && lastbits >= 0) s.bits = 5'(lastbits);
      s.mcu  = 16'(mcu);
      e.data = s.data;
      e.last = s.last;
      e.bits = s.last ? s.bits : 5'd0;
      e.comp = 2'(comp);
      if (comp == 0) yq.push_back(s);
      else if (comp == 1) cbq.push_back(s);
      else crq.push_back(s);
      sbq.push_back(e);
    end
  endtask

  task automatic gen_image(input int n, input int yp, input int maxw);
    for (int m = 0; m < n; m++) begin
      for (int b = 0; b < yp; b++) push_block(0, m, 1 + int'($urandom_range(0, maxw - 1)), -1);
      push_block(1, m, 1 + int'($urandom_range(0, maxw - 1)), -1);
      push_block(2, m, 1 + int'($urandom_range(0, maxw - 1)), -1);
    end
  endtask

  // Runs the image already queued; a second start mid-image must be ignored.
  task automatic run_image(input logic s, input int n, input int mode);
    int k;
    sel = s;
    rmode = mode;
    out_seen = 0;
    done_seen = 0;
    drv_en = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    stall_lo = cyc + 6;
    start = 1'b1; num_mcu = 16'(n);
    @(negedge clk);
    start = 1'b0; num_mcu = 16'(n + 5);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (sbq.size() != 0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("image_words_left", 32'(sbq.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("done_count", 32'(done_seen), 32'd1);
    chk("busy_after_image", 32'(busy), 32'd0);
    chk("src_words_left", 32'(yq.size() + cbq.size() + crq.size()), 32'd0);
    drv_en = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
  endtask

  // Source and sink driver: present queue heads, pick out_ready, retire accepted words.
  always @(negedge clk) begin
    cyc++;
    if (drv_en) begin
      y_valid  = (yq.size() != 0);
      cb_valid = (cbq.size() != 0);
      cr_valid = (crq.size() != 0);
      y_data  = y_valid  ? yq[0].data  : $urandom;
      y_last  = y_valid  ? yq[0].last  : 1'b0;
      y_bits  = y_valid  ? yq[0].bits  : 5'd0;
      cb_data = cb_valid ? cbq[0].data : $urandom;
      cb_last = cb_valid ? cbq[0].last : 1'b0;
      cb_bits = cb_valid ? cbq[0].bits : 5'd0;
      cr_data = cr_valid ? crq[0].data : $urandom;
      cr_last = cr_valid ? crq[0].last : 1'b0;
      cr_bits = cr_valid ? crq[0].bits : 5'd0;
      if (rmode == 0) out_ready = 1'b1;
      else if (rmode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = !(cyc >= stall_lo && cyc < stall_lo + 5);
      #1;
      chk("ready_count", 32'(int'(y_ready) + int'(cb_ready) + int'(cr_ready) <= 1), 32'd1);
      if (y_valid && y_ready) begin
        chk("y_mcu_idx", 32'(mcu_idx), 32'(yq[0].mcu));
        void'(yq.pop_front());
      end
      if (cb_valid && cb_ready) begin
        chk("cb_mcu_idx", 32'(mcu_idx), 32'(cbq[0].mcu));
        void'(cbq.pop_front());
      end
      if (cr_valid && cr_ready) begin
        chk("cr_mcu_idx", 32'(mcu_idx), 32'(crq[0].mcu));
        void'(crq.pop_front());
      end
    end
  end

  // Monitor: compare consumed words against the scoreboard, check hold and done.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (mon_en) begin
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", 32'(out_last), 32'(prev_last));
        chk("hold_bits", 32'(out_bits), 32'(prev_bits));
        chk("hold_comp", 32'(out_comp), 32'(prev_comp));
      end
      if (out_valid && !out_ready)
        chk("ready_while_stalled", 32'({y_ready, cb_ready, cr_ready}), 32'd0);
      chk("done_pulse", 32'(done), 32'(done_exp));
      if (done) done_seen++;
      done_exp = 1'b0;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", 32'(out_last), 32'(e.last));
          chk("out_bits", 32'(out_bits), 32'(e.bits));
          chk("out_comp", 32'(out_comp), 32'(e.comp));
          if (out_seen == 0) first_out_cyc = cyc;
          last_out_cyc = cyc;
          out_seen++;
          if (sbq.size() == 0) done_exp = 1'b1;
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      prev_bits = out_bits;
      prev_comp = out_comp;
    end else begin
      hold_prev = 1'b0;
      done_exp  = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; start = 1'b0; sel = 1'b0; out_ready = 1'b0; num_mcu = 16'd0;
    y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0;
    y_data = '0; cb_data = '0; cr_data = '0;
    y_last = 1'b0; cb_last = 1'b0; cr_last = 1'b0;
    y_bits = '0; cb_bits = '0; cr_bits = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'({out_valid_1, out_valid_4}), 32'd0);
    chk("rst_busy_done", 32'({busy_1, busy_4, done_1, done_4}), 32'd0);
    chk("rst_out_data", out_data_1 | out_data_4, 32'd0);
    chk("rst_mcu_idx", 32'(mcu_idx_1 | mcu_idx_4), 32'd0);
    chk("rst_bits_comp", 32'({out_bits_1, out_bits_4, out_comp_1, out_comp_4, out_last_1, out_last_4}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // One MCU, Y two words (bits 7), Cb bits 3, Cr bits 0; all valids up, no bubbles.
    push_block(0, 0, 2, 7);
    push_block(1, 0, 1, 3);
    push_block(2, 0, 1, 0);
    run_image(1'b0, 1, 0);
    chk("t1_words", 32'(out_seen), 32'd4);
    chk("t1_no_bubble", 32'(last_out_cyc - first_out_cyc), 32'd3);

    // Random block sizes with random backpressure.
    gen_image(5, 1, 4);
    run_image(1'b0, 5, 1);

    // Five-cycle downstream stall in the middle of a long Y block.
    push_block(0, 0, 8, -1);
    push_block(1, 0, 2, -1);
    push_block(2, 0, 1, -1);
    run_image(1'b0, 1, 2);
    chk("t3_words", 32'(out_seen), 32'd11);

    // 4:2:0 layout: four Y blocks per MCU, two MCUs, then a randomised run.
    gen_image(2, 4, 3);
    run_image(1'b1, 2, 0);
    gen_image(3, 4, 3);
    run_image(1'b1, 3, 1);

    // Empty image: no grants, busy for one cycle, done two cycles after start.
    sel = 1'b0;
    y_valid = 1'b1; cb_valid = 1'b1; cr_valid = 1'b1; out_ready = 1'b1;
    start = 1'b1; num_mcu = 16'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("t5_busy_c1", 32'({busy, done}), 32'b10);
    chk("t5_ready_c1", 32'({y_ready, cb_ready, cr_ready}), 32'd0);
    @(negedge clk);
    #1;
    chk("t5_busy_c2", 32'({busy, done}), 32'b01);
    chk("t5_ready_c2", 32'({y_ready, cb_ready, cr_ready}), 32'd0);
    @(negedge clk);
    #1;
    chk("t5_busy_c3", 32'({busy, done}), 32'b00);
    chk("t5_ready_c3", 32'({y_ready, cb_ready, cr_ready}), 32'd0);
    y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0;
    @(negedge clk);

    // Reset while Cb is granted and a Y word is held downstream.
    out_ready = 1'b0;
    start = 1'b1; num_mcu = 16'd1;
    @(negedge clk);
    start = 1'b0;
    y_valid = 1'b1; y_last = 1'b1; y_data = 32'hA5A5_0001; y_bits = 5'd9;
    @(negedge clk);
    y_valid = 1'b0; cb_valid = 1'b1; cb_last = 1'b0;
    #1;
    chk("t6_pre_held", 32'({out_valid, out_comp, out_bits}), 32'({1'b1, 2'd0, 5'd9}));
    chk("t6_pre_data", out_data, 32'hA5A5_0001);
    chk("t6_pre_cb_ready", 32'(cb_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid_busy", 32'({out_valid, busy, done}), 32'd0);
    chk("t6_rst_data", out_data, 32'd0);
    chk("t6_rst_ready", 32'({y_ready, cb_ready, cr_ready}), 32'd0);
    chk("t6_rst_misc", 32'({out_last, out_bits, out_comp, mcu_idx}), 32'd0);
    @(negedge clk);
    cb_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    gen_image(2, 1, 3);
    run_image(1'b0, 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
